code_index_sequencer: RTL and testbench
=======================================

# code_index_sequencer

Registered source of the 3-bit code index that drives the gray/one-hot code converter's `A` input. It steps a 3-bit index at a programmable rate (up, down, or ping-pong) from a loaded start value, either free-running with wrap-around or as a one-shot sweep. Its `idx` output connects directly to the converter, and `step` marks every index change for downstream capture logic.

## Interface
- `PRESCALE`, default 4: clock cycles per index step; legal range is ≥1.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load `load_val` and begin a run; sampled each cycle.
- `stop`  in  1  abort the run; stop has priority over `start` and over a step.
- `load_val`  in  3  starting index, captured on an accepted `start`.
- `dir`  in  1  0 = count up, 1 = count down; latched at `start`.
- `one_shot`  in  1  1 = finish at the end value, 0 = wrap; latched at `start`.
- `bounce`  in  1  1 = ping-pong; latched at `start`; used only when `SEQ_PINGPONG_EN` is defined.
- `idx`  out  3  current index; feeds the converter's `A` input.
- `step`  out  1  one-cycle pulse in the cycle `idx` takes a new value, including the load.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a one-shot run completes.

## Operation
- **States:** IDLE, RUN, DONE. All outputs are registered.
- **Reset values:** state = IDLE; `idx` = 0; `step` = `busy` = `done` = 0; prescaler = 0; latched direction = up.
- **IDLE or DONE:**
  - `start`=1 and `stop`=0: go to RUN; `idx` ← `load_val`; `step`=1; `busy`=1; prescaler ← 0; latch `dir`, `one_shot`, `bounce`.
  - Otherwise: stay in IDLE (DONE always exits to IDLE).
- **RUN:**
  - Prescaler counts 0 to PRESCALE-1 and wraps. The wrap cycle is a step event.
  - On a step event:
    - Up: `idx` + 1. Down: `idx` − 1. Arithmetic is modulo 8 (7→0 up, 0→7 down).
    - `step`=1 for that one cycle.
- **One-shot** (`one_shot`=1):
  - End value is 7 for up, 0 for down.
  - A step event with `idx` at the end value does not change `idx`, does not assert `step`, and moves to DONE.
  - In DONE: `done`=1, `busy`=0, `idx` holds.
  - If `load_val` already equals the end value, DONE follows after one prescale period.
- **Ping-pong** (`bounce`=1, `one_shot`=0):
  - At a step event with `idx`=7 while moving up: the latched direction flips to down and `idx` becomes 6.
  - Symmetric at 0 while moving down: the direction flips to up and `idx` becomes 1.
  - With `one_shot`=1, `bounce` is ignored.
- **`stop`=1 in RUN:** go to IDLE next edge; `idx` holds; no `step`, no `done`.
  - If a step event falls in the same cycle, the step is suppressed.
- **`start`=1 in RUN** (with `stop`=0): restart exactly as from IDLE; a pending step event is discarded.
- **`start` and `stop` together in IDLE:** ignored; stay in IDLE.
- **Reset asserted mid-run:** all state returns to reset values immediately, independent of the clock.

## Timing
- `start` sampled at edge N: `idx`=`load_val` and `step`=1 are visible after N.
- Steps occur at edges N+k·PRESCALE, k ≥ 1.
- PRESCALE=1: one step per cycle.
- `done` is high for exactly one cycle, starting at the edge that would have been the next step. `busy` falls on that same edge.
- `stop` at edge M: `busy`=0 after M.
- `idx` is stable between `step` pulses, so the combinational converter output settles within the same cycle.

## Configuration
- Macro: `SEQ_PINGPONG_EN`.
- **Defined:** ping-pong behaviour is as described above, and the latched direction register may change during a run.
- **Undefined:**
  - The `bounce` port is still present but ignored (treated as 0).
  - The latched direction is constant for the whole run; `dir` is the only direction source.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → `idx`=0, `busy`=0, `step`=0, `done`=0 immediately.
- **Wrap up:** PRESCALE=4, `load_val`=6, `dir`=0, `one_shot`=0 → `idx` sequence 6,7,0,1 with a `step` pulse every 4 cycles.
- **One-shot down:** PRESCALE=2, `load_val`=2, `dir`=1, `one_shot`=1 → `idx` 2,1,0; `done` pulses 2 cycles after `idx`=0; `busy` drops with `done`; `idx` holds 0.
- **Ping-pong** (`SEQ_PINGPONG_EN`): PRESCALE=1, `load_val`=5, `bounce`=1 → `idx` 5,6,7,6,5,…,0,1.
- **Stop/step collision:** PRESCALE=3, assert `stop` in the step-event cycle → no `step`, `idx` unchanged, `busy`=0 next cycle.
- **Restart:** `start` with `load_val`=3 in RUN → `idx`=3, `step`=1, prescaler cleared, next step 3 cycles later; `start`+`stop` together in IDLE → no change.

Source files
------------

// File: rtl/code_index_sequencer_if.sv
// Handshake/control bundle between a controller and code_index_sequencer.
// The controller side drives run control; the sequencer side returns the index and status pulses.
interface code_index_sequencer_if;
  logic       start;
  logic       stop;
  logic [2:0] load_val;
  logic       dir;
  logic       one_shot;
  logic       bounce;
  logic [2:0] idx;
  logic       step;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, load_val, dir, one_shot, bounce,
    input  idx, step, busy, done
  );

  modport slave (
    input  start, stop, load_val, dir, one_shot, bounce,
    output idx, step, busy, done
  );
endinterface

// File: rtl/code_index_sequencer.sv
// Registered 3-bit code index source stepping up/down/ping-pong at a PRESCALE rate.
// Optional feature macro: SEQ_PINGPONG_EN enables ping-pong reversal at the index extremes.
module code_index_sequencer #(
  parameter int PRESCALE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  code_index_sequencer_if.slave bus
);

  localparam int CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            step_q, step_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            oneShot_q, oneShot_d;
  logic            loadReq, stepEvent, atEnd, doLoad;

`ifdef SEQ_PINGPONG_EN
  logic            bounce_q, bounce_d;
`else
  logic            unusedBounce;
  assign unusedBounce = bus.bounce;
`endif

  assign loadReq   = bus.start && !bus.stop;
  assign stepEvent = (cnt_q == CntMax);
  assign atEnd     = dir_q ? (idx_q == 3'd0) : (idx_q == 3'd7);

  // Next-state: stop beats start, start beats a pending step; loads share one path.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    step_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    oneShot_d = oneShot_q;
    doLoad    = 1'b0;
`ifdef SEQ_PINGPONG_EN
    bounce_d  = bounce_q;
`endif

    case (state_q)
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (loadReq) begin
          doLoad = 1'b1;
        end else begin
          cnt_d = stepEvent ? '0 : cnt_q + CntW'(1);
          if (stepEvent) begin
            if (oneShot_q && atEnd) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
`ifdef SEQ_PINGPONG_EN
            else if (bounce_q && atEnd) begin
              dir_d  = !dir_q;
              idx_d  = dir_q ? 3'd1 : 3'd6;
              step_d = 1'b1;
            end
`endif
            else begin
              idx_d  = dir_q ? idx_q - 3'd1 : idx_q + 3'd1;
              step_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (loadReq) begin
          doLoad = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase

    if (doLoad) begin
      state_d   = RUN;
      idx_d     = bus.load_val;
      step_d    = 1'b1;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      cnt_d     = '0;
      dir_d     = bus.dir;
      oneShot_d = bus.one_shot;
`ifdef SEQ_PINGPONG_EN
      bounce_d  = bus.bounce;
`endif
    end
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      oneShot_q <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      bounce_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      oneShot_q <= oneShot_d;
`ifdef SEQ_PINGPONG_EN
      bounce_q  <= bounce_d;
`endif
    end
  end

  assign bus.idx  = idx_q;
  assign bus.step = step_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_code_index_sequencer.sv
// Directed bench for code_index_sequencer: dutA runs at PRESCALE=4, dutB at PRESCALE=1.
// Both share one stimulus bundle; each check targets the instance it is written for.
module tb_code_index_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       startIn, stopIn, dirIn, oneShotIn, bounceIn;
  logic [2:0] loadValIn;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] ppExp [0:11];

  code_index_sequencer_if busA ();
  code_index_sequencer_if busB ();

  assign busA.start    = startIn;
  assign busA.stop     = stopIn;
  assign busA.load_val = loadValIn;
  assign busA.dir      = dirIn;
  assign busA.one_shot = oneShotIn;
  assign busA.bounce   = bounceIn;
  assign busB.start    = startIn;
  assign busB.stop     = stopIn;
  assign busB.load_val = loadValIn;
  assign busB.dir      = dirIn;
  assign busB.one_shot = oneShotIn;
  assign busB.bounce   = bounceIn;

  code_index_sequencer #(.PRESCALE(4)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  code_index_sequencer #(.PRESCALE(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic p, input logic [2:0] lv,
                               input logic d, input logic o, input logic b);
    startIn   = s;
    stopIn    = p;
    loadValIn = lv;
    dirIn     = d;
    oneShotIn = o;
    bounceIn  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef SEQ_PINGPONG_EN
    ppExp = '{3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
`else
    ppExp = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
`endif
    rst_n = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset idx", busA.idx, 0);
    checkOutput("reset step", busA.step, 0);
    checkOutput("reset busy", busA.busy, 0);
    checkOutput("reset done", busA.done, 0);
    rst_n = 1'b1;
    tick();

    // Wrap up from 6 at PRESCALE=4
    applyStimulus(1, 0, 3'd6, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd6, 0, 0, 0);
    checkOutput("wrap load idx", busA.idx, 6);
    checkOutput("wrap load step", busA.step, 1);
    checkOutput("wrap load busy", busA.busy, 1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      checkOutput($sformatf("wrap idx c=%0d", c), busA.idx, 8'((6 + c / 4) % 8));
      checkOutput($sformatf("wrap step c=%0d", c), busA.step, (c % 4 == 0) ? 8'd1 : 8'd0);
    end

    // Stop in the step-event cycle
    tick();
    tick();
    tick();
    applyStimulus(0, 1, 3'd6, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd6, 0, 0, 0);
    checkOutput("collide idx", busA.idx, 1);
    checkOutput("collide step", busA.step, 0);
    checkOutput("collide busy", busA.busy, 0);
    checkOutput("collide done", busA.done, 0);
    checkOutput("stop busyB", busB.busy, 0);

    // start together with stop while idle is ignored
    applyStimulus(1, 1, 3'd5, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd5, 0, 0, 0);
    checkOutput("ss idle idx", busA.idx, 1);
    checkOutput("ss idle step", busA.step, 0);
    checkOutput("ss idle busy", busA.busy, 0);

    // Restart in the step-event cycle discards the pending step
    applyStimulus(1, 0, 3'd2, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd2, 0, 0, 0);
    checkOutput("rs load idx", busA.idx, 2);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput($sformatf("rs wait step c=%0d", c), busA.step, 0);
    end
    applyStimulus(1, 0, 3'd3, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd3, 0, 0, 0);
    checkOutput("restart idx", busA.idx, 3);
    checkOutput("restart step", busA.step, 1);
    checkOutput("restart busy", busA.busy, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("restart idx c=%0d", c), busA.idx, (c == 4) ? 8'd4 : 8'd3);
      checkOutput($sformatf("restart step c=%0d", c), busA.step, (c == 4) ? 8'd1 : 8'd0);
    end
    applyStimulus(0, 1, 3'd3, 0, 0, 0);
    tick();

    // One-shot down from 2 at PRESCALE=4
    applyStimulus(1, 0, 3'd2, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 3'd2, 1, 1, 0);
    checkOutput("os load idx", busA.idx, 2);
    checkOutput("os load step", busA.step, 1);
    for (int c = 1; c <= 13; c++) begin
      tick();
      checkOutput($sformatf("os idx c=%0d", c), busA.idx, (c < 4) ? 8'd2 : (c < 8) ? 8'd1 : 8'd0);
      checkOutput($sformatf("os step c=%0d", c), busA.step, (c % 4 == 0 && c < 12) ? 8'd1 : 8'd0);
      checkOutput($sformatf("os done c=%0d", c), busA.done, (c == 12) ? 8'd1 : 8'd0);
      checkOutput($sformatf("os busy c=%0d", c), busA.busy, (c < 12) ? 8'd1 : 8'd0);
    end

    // One-shot up loaded at the end value: done after one prescale period
    applyStimulus(1, 0, 3'd7, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 3'd7, 0, 1, 0);
    checkOutput("osend load idx", busA.idx, 7);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("osend done c=%0d", c), busA.done, (c == 4) ? 8'd1 : 8'd0);
      checkOutput($sformatf("osend step c=%0d", c), busA.step, 0);
      checkOutput($sformatf("osend idx c=%0d", c), busA.idx, 7);
    end

    // Bounce request on dutB at PRESCALE=1
    applyStimulus(1, 0, 3'd5, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 3'd5, 0, 0, 1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      checkOutput($sformatf("pp idx c=%0d", c), busB.idx, 8'(ppExp[c]));
      checkOutput($sformatf("pp step c=%0d", c), busB.step, 1);
    end
    applyStimulus(0, 1, 3'd5, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd5, 0, 0, 0);

    // Asynchronous reset in the middle of a run
    applyStimulus(1, 0, 3'd5, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3'd5, 0, 0, 0);
    checkOutput("pre-rst idx", busA.idx, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst idx", busA.idx, 0);
    checkOutput("async rst step", busA.step, 0);
    checkOutput("async rst busy", busA.busy, 0);
    checkOutput("async rst done", busA.done, 0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
